am9513_cai_decoder: RTL and testbench

//  Decode stage between CAI submit queue and Am9513 execute units: registers each submitted

---
 rtl/am9513_cai_decoder_if.sv | 56 +++++
 rtl/am9513_cai_decoder.sv | 238 +++++++++++++++++++++++
 tb/tb_am9513_cai_decoder.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/am9513_cai_decoder_if.sv
// ---------------------------------------------------------------------------
// am9513_cai_decoder_if
//   Descriptor-in / decoded-op-out bus of the CAI decode stage.
//   master : the side that submits descriptors and consumes decoded ops
//            (drives in_* data/valid and out_ready).
//   slave  : the decode stage itself.
// Parameters
//   CTX_W  context id width
//   TAG_W  opaque tag width
//   REG_W  result-register index width
// Signals
//   in_valid/in_ready, in_opcode, in_flags, in_ctx, in_tag   submit side
//   out_valid/out_ready, out_func, out_fmt, out_src_fmt,
//   out_mode_valid, out_mode, out_res_valid, out_res_reg,
//   out_ctx, out_tag, out_illegal, out_cause                 decoded side
// ---------------------------------------------------------------------------
interface am9513_cai_decoder_if #(
  parameter int CTX_W = 2,
  parameter int TAG_W = 8,
  parameter int REG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_opcode;
  logic [31:0]      in_flags;
  logic [CTX_W-1:0] in_ctx;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_func;
  logic [7:0]       out_fmt;
  logic [7:0]       out_src_fmt;
  logic             out_mode_valid;
  logic [2:0]       out_mode;
  logic             out_res_valid;
  logic [REG_W-1:0] out_res_reg;
  logic [CTX_W-1:0] out_ctx;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic [2:0]       out_cause;

  modport master (
    output in_valid, in_opcode, in_flags, in_ctx, in_tag, out_ready,
    input  in_ready, out_valid, out_func, out_fmt, out_src_fmt,
           out_mode_valid, out_mode, out_res_valid, out_res_reg,
           out_ctx, out_tag, out_illegal, out_cause
  );

  modport slave (
    input  in_valid, in_opcode, in_flags, in_ctx, in_tag, out_ready,
    output in_ready, out_valid, out_func, out_fmt, out_src_fmt,
           out_mode_valid, out_mode, out_res_valid, out_res_reg,
           out_ctx, out_tag, out_illegal, out_cause
  );
endinterface

// File: rtl/am9513_cai_decoder.sv
// ---------------------------------------------------------------------------
// am9513_cai_decoder
//   Decode stage between the CAI submit queue and the Am9513 execute units.
//   Each accepted descriptor is decoded (func/fmt/mode/result register),
//   checked for legality against the active personality tier, and presented
//   one cycle later through an output register backed by a 1-entry skid
//   buffer. Also keeps sticky IEEE exception flags (NV,DZ,OF,UF,NX in bits
//   0..4) for NUM_CTX contexts and a saturating count of illegal ops issued.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   tier              active personality code (0=P0 .. 4=P4), quasi-static
//   bus               descriptor/decoded-op handshake bus (slave side)
//   flag_set_v/ctx/set  OR flag_set into the flags of flag_set_ctx
//   flag_clr_v/ctx    clear the flags of flag_clr_ctx
//   flag_rd_ctx/data  combinational read of the registered flags
//   illegal_cnt       saturating count of ops issued with out_illegal=1
// ---------------------------------------------------------------------------
module am9513_cai_decoder #(
  parameter  int NUM_CTX = 4,
  parameter  int TAG_W   = 8,
  parameter  int REG_W   = 4,
  localparam int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           tier,
  am9513_cai_decoder_if.slave  bus,
  input  logic                 flag_set_v,
  input  logic [CTX_W-1:0]     flag_set_ctx,
  input  logic [4:0]           flag_set,
  input  logic                 flag_clr_v,
  input  logic [CTX_W-1:0]     flag_clr_ctx,
  input  logic [CTX_W-1:0]     flag_rd_ctx,
  output logic [4:0]           flag_rd_data,
  output logic [15:0]          illegal_cnt
);

  typedef struct packed {
    logic [7:0]       func;
    logic [7:0]       fmt;
    logic [7:0]       src_fmt;
    logic             mode_valid;
    logic [2:0]       mode;
    logic             res_valid;
    logic [REG_W-1:0] res_reg;
    logic [CTX_W-1:0] ctx;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic [2:0]       cause;
  } op_t;

  localparam logic [2:0] CAUSE_OK        = 3'd0;
  localparam logic [2:0] CAUSE_NO_VENDOR = 3'd1;
  localparam logic [2:0] CAUSE_UNKNOWN   = 3'd2;
  localparam logic [2:0] CAUSE_TIER      = 3'd3;
  localparam logic [2:0] CAUSE_BAD_MODE  = 3'd4;

  // Legality check; the first failing rule determines the cause.
  // Function groups: 01-05 base (P0), 06-0A and 10-14 need P1,
  // 20-27 (transcendentals) need P2. Tiers above 2 behave as P2.
  function automatic logic [2:0] legality_cause(
    input logic [31:0] opcode,
    input logic [31:0] flags,
    input logic [7:0]  tier_code
  );
    logic [7:0] func;
    logic       grp_base;
    logic       grp_ext;
    logic       grp_trans;
    logic [2:0] cause;
    func      = opcode[7:0];
    grp_base  = (func >= 8'h01) && (func <= 8'h05);
    grp_ext   = ((func >= 8'h06) && (func <= 8'h0A)) ||
                ((func >= 8'h10) && (func <= 8'h14));
    grp_trans = (func >= 8'h20) && (func <= 8'h27);
    if (!opcode[31]) begin
      cause = CAUSE_NO_VENDOR;
    end else if (!(grp_base || grp_ext || grp_trans)) begin
      cause = CAUSE_UNKNOWN;
    end else if ((grp_ext && (tier_code < 8'd1)) ||
                 (grp_trans && (tier_code < 8'd2))) begin
      cause = CAUSE_TIER;
    end else if (flags[0] && (flags[3:1] > 3'd2)) begin
      cause = CAUSE_BAD_MODE;
    end else begin
      cause = CAUSE_OK;
    end
    return cause;
  endfunction

  op_t             dec_s;
  op_t             out_r;
  op_t             out_nx_s;
  op_t             skid_r;
  op_t             skid_nx_s;
  logic            out_valid_r;
  logic            out_valid_nx_s;
  logic            skid_full_r;
  logic            skid_full_nx_s;
  logic            in_ready_r;
  logic            accept_s;
  logic            out_fire_s;
  logic            out_load_s;
  logic [4:0]      flags_r    [NUM_CTX];
  logic [4:0]      flags_nx_s [NUM_CTX];
  logic [15:0]     illegal_cnt_r;
  logic            unused_bits_s;

  // Only a subset of the opcode/flag words carries meaning here.
  assign unused_bits_s = ^{bus.in_opcode, bus.in_flags};

  assign accept_s   = bus.in_valid && in_ready_r;
  assign out_fire_s = out_valid_r && bus.out_ready;
  // The output register may take a new op when it is empty or being drained.
  assign out_load_s = out_fire_s || !out_valid_r;

  // Decode the incoming descriptor; fields are decoded even when illegal.
  always_comb begin
    dec_s            = '0;
    dec_s.func       = bus.in_opcode[7:0];
    dec_s.fmt        = bus.in_opcode[15:8];
    dec_s.src_fmt    = (bus.in_opcode[7:0] == 8'h10) ? bus.in_flags[7:0] : 8'h00;
    dec_s.mode_valid = bus.in_flags[0];
    dec_s.mode       = bus.in_flags[3:1];
    dec_s.res_valid  = bus.in_flags[4];
    dec_s.res_reg    = bus.in_flags[8 +: REG_W];
    dec_s.ctx        = bus.in_ctx;
    dec_s.tag        = bus.in_tag;
    dec_s.cause      = legality_cause(bus.in_opcode, bus.in_flags, tier);
    dec_s.illegal    = (dec_s.cause != CAUSE_OK);
  end

  // Next state of output register and skid buffer. The skid only fills
  // while the output is stalled, and always drains into the output first,
  // which keeps ops strictly in order. in_ready tracks the skid so that an
  // accept never coincides with a full skid.
  always_comb begin
    out_nx_s       = out_r;
    out_valid_nx_s = out_valid_r;
    skid_nx_s      = skid_r;
    skid_full_nx_s = skid_full_r;
    if (out_load_s) begin
      if (skid_full_r) begin
        out_nx_s       = skid_r;
        out_valid_nx_s = 1'b1;
        skid_full_nx_s = 1'b0;
      end else if (accept_s) begin
        out_nx_s       = dec_s;
        out_valid_nx_s = 1'b1;
      end else begin
        out_valid_nx_s = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_nx_s      = dec_s;
        skid_full_nx_s = 1'b1;
      end else begin
        skid_full_nx_s = skid_full_r;
      end
    end
  end

  // Pipeline registers; in_ready comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= '0;
      out_valid_r <= 1'b0;
      skid_r      <= '0;
      skid_full_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      out_r       <= out_nx_s;
      out_valid_r <= out_valid_nx_s;
      skid_r      <= skid_nx_s;
      skid_full_r <= skid_full_nx_s;
      in_ready_r  <= !skid_full_nx_s;
    end
  end

  // Sticky flag update: a same-cycle clear acts before the set, so bits
  // set in that cycle survive. Out-of-range contexts match no entry.
  always_comb begin
    for (int c = 0; c < NUM_CTX; c++) begin
      flags_nx_s[c] = (flag_clr_v && (flag_clr_ctx == CTX_W'(c))) ? 5'b00000 : flags_r[c];
      flags_nx_s[c] = flags_nx_s[c] |
                      ((flag_set_v && (flag_set_ctx == CTX_W'(c))) ? flag_set : 5'b00000);
    end
  end

  // Per-context flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        flags_r[c] <= 5'b00000;
      end
    end else begin
      for (int c = 0; c < NUM_CTX; c++) begin
        flags_r[c] <= flags_nx_s[c];
      end
    end
  end

  // Flag read port; an out-of-range context reads as zero.
  always_comb begin
    flag_rd_data = 5'b00000;
    for (int c = 0; c < NUM_CTX; c++) begin
      flag_rd_data = flag_rd_data |
                     ((flag_rd_ctx == CTX_W'(c)) ? flags_r[c] : 5'b00000);
    end
  end

  // Saturating count of illegal ops handed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt_r <= 16'h0000;
    end else if (out_fire_s && out_r.illegal && (illegal_cnt_r != 16'hFFFF)) begin
      illegal_cnt_r <= illegal_cnt_r + 16'd1;
    end else begin
      illegal_cnt_r <= illegal_cnt_r;
    end
  end

  assign illegal_cnt        = illegal_cnt_r;
  assign bus.in_ready       = in_ready_r;
  assign bus.out_valid      = out_valid_r;
  assign bus.out_func       = out_r.func;
  assign bus.out_fmt        = out_r.fmt;
  assign bus.out_src_fmt    = out_r.src_fmt;
  assign bus.out_mode_valid = out_r.mode_valid;
  assign bus.out_mode       = out_r.mode;
  assign bus.out_res_valid  = out_r.res_valid;
  assign bus.out_res_reg    = out_r.res_reg;
  assign bus.out_ctx        = out_r.ctx;
  assign bus.out_tag        = out_r.tag;
  assign bus.out_illegal    = out_r.illegal;
  assign bus.out_cause      = out_r.cause;

endmodule

// File: tb/tb_am9513_cai_decoder.sv
// ---------------------------------------------------------------------------
// tb_am9513_cai_decoder
//   Scoreboard bench: accepted descriptors push the reference-model result,
//   a negedge monitor pops and compares whenever a decoded op is handed off.
// ---------------------------------------------------------------------------
module tb_am9513_cai_decoder;
  localparam int NUM_CTX = 4;
  localparam int CTX_W   = 2;
  localparam int TAG_W   = 8;
  localparam int REG_W   = 4;

  typedef struct packed {
    logic [7:0]       func;
    logic [7:0]       fmt;
    logic [7:0]       src_fmt;
    logic             mode_valid;
    logic [2:0]       mode;
    logic             res_valid;
    logic [REG_W-1:0] res_reg;
    logic [CTX_W-1:0] ctx;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic [2:0]       cause;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       tier;
  logic             flag_set_v;
  logic [CTX_W-1:0] flag_set_ctx;
  logic [4:0]       flag_set;
  logic             flag_clr_v;
  logic [CTX_W-1:0] flag_clr_ctx;
  logic [CTX_W-1:0] flag_rd_ctx;
  logic [4:0]       flag_rd_data;
  logic [15:0]      illegal_cnt;

  am9513_cai_decoder_if #(.CTX_W(CTX_W), .TAG_W(TAG_W), .REG_W(REG_W)) bus ();

  am9513_cai_decoder #(.NUM_CTX(NUM_CTX), .TAG_W(TAG_W), .REG_W(REG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tier         (tier),
    .bus          (bus),
    .flag_set_v   (flag_set_v),
    .flag_set_ctx (flag_set_ctx),
    .flag_set     (flag_set),
    .flag_clr_v   (flag_clr_v),
    .flag_clr_ctx (flag_clr_ctx),
    .flag_rd_ctx  (flag_rd_ctx),
    .flag_rd_data (flag_rd_data),
    .illegal_cnt  (illegal_cnt)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         model_ill_cnt = 0;
  logic [4:0] mflags [NUM_CTX];
  logic [4:0] pend   [NUM_CTX];
  bit         rdy_rand = 1'b0;
  logic       rdy_fixed = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decode rules expressed as a table of function ranges
  // and the minimum tier each range needs.
  function automatic exp_t model(input logic [31:0] op, input logic [31:0] fl,
                                 input logic [7:0] t, input logic [CTX_W-1:0] ctx,
                                 input logic [TAG_W-1:0] tag);
    exp_t e;
    int   need;
    int   level;
    logic [7:0] f;
    f = op[7:0];
    level = (t > 8'd2) ? 2 : int'(t);
    if (f inside {[8'h01:8'h05]})                      need = 0;
    else if (f inside {[8'h06:8'h0A], [8'h10:8'h14]})  need = 1;
    else if (f inside {[8'h20:8'h27]})                 need = 2;
    else                                               need = -1;
    e.func       = f;
    e.fmt        = op[15:8];
    e.src_fmt    = (f == 8'h10) ? fl[7:0] : 8'h00;
    e.mode_valid = fl[0];
    e.mode       = fl[3:1];
    e.res_valid  = fl[4];
    e.res_reg    = fl[11:8];
    e.ctx        = ctx;
    e.tag        = tag;
    if (op[31] == 1'b0)                 e.cause = 3'd1;
    else if (need < 0)                  e.cause = 3'd2;
    else if (level < need)              e.cause = 3'd3;
    else if (fl[0] && (fl[3:1] > 3'd2)) e.cause = 3'd4;
    else                                e.cause = 3'd0;
    e.illegal = (e.cause != 3'd0);
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t a;
    a.func       = bus.out_func;
    a.fmt        = bus.out_fmt;
    a.src_fmt    = bus.out_src_fmt;
    a.mode_valid = bus.out_mode_valid;
    a.mode       = bus.out_mode;
    a.res_valid  = bus.out_res_valid;
    a.res_reg    = bus.out_res_reg;
    a.ctx        = bus.out_ctx;
    a.tag        = bus.out_tag;
    a.illegal    = bus.out_illegal;
    a.cause      = bus.out_cause;
    return a;
  endfunction

  // Monitor: pop/compare on output handoff, then push on input acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("op_decode", 64'(observed()), 64'(e));
          if (e.illegal && (model_ill_cnt < 65535)) model_ill_cnt++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.in_opcode, bus.in_flags, tier, bus.in_ctx, bus.in_tag));
      end
    end
  end

  // Downstream ready: random back-pressure or a fixed level.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rdy_rand ? ($urandom_range(0, 9) < 7) : rdy_fixed;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Present one descriptor and hold it until accepted (called at posedge+1).
  task automatic send(input logic [31:0] op, input logic [31:0] fl,
                      input logic [CTX_W-1:0] ctx, input logic [TAG_W-1:0] tag);
    int guard;
    guard = 0;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_flags  = fl;
    bus.in_ctx    = ctx;
    bus.in_tag    = tag;
    @(negedge clk);
    while (!bus.in_ready && (guard < 200)) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic rand_send();
    logic [7:0]  f;
    logic [31:0] op;
    int          r;
    r = $urandom_range(0, 9);
    if (r < 3)      f = 8'($urandom_range(1, 10));
    else if (r < 5) f = 8'($urandom_range(16, 20));
    else if (r < 7) f = 8'($urandom_range(32, 39));
    else if (r < 8) f = 8'h10;
    else            f = 8'($urandom);
    op   = {($urandom_range(0, 9) != 0), 15'($urandom), 8'($urandom), f};
    tier = 8'($urandom_range(0, 4));
    send(op, $urandom, CTX_W'($urandom), TAG_W'($urandom));
  endtask

  task automatic drain_and_check();
    rdy_rand  = 1'b0;
    rdy_fixed = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("illegal_cnt", 64'(illegal_cnt), 64'(model_ill_cnt));
  endtask

  initial begin
    rst_n = 1'b0;
    tier = 8'd2;
    bus.in_valid = 1'b0; bus.in_opcode = 32'h0; bus.in_flags = 32'h0;
    bus.in_ctx = '0; bus.in_tag = '0;
    flag_set_v = 1'b0; flag_set_ctx = '0; flag_set = 5'h0;
    flag_clr_v = 1'b0; flag_clr_ctx = '0; flag_rd_ctx = '0;
    for (int c = 0; c < NUM_CTX; c++) mflags[c] = 5'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
    check("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
    check("rst_out_data", 64'({bus.out_func, bus.out_fmt, bus.out_tag, bus.out_cause}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready_high", 64'(bus.in_ready), 64'd1);
    flag_rd_ctx = 2'd3;
    #1;
    check("rst_flags", 64'(flag_rd_data), 64'd0);
    @(posedge clk);
    #1;

    // Basic decode, 1-cycle latency
    tier = 8'd2;
    send(32'h8000_0801, 32'h0, 2'd1, 8'h5A);
    check("t1_out_valid", 64'(bus.out_valid), 64'd1);
    check("t1_func_fmt_cause", 64'({bus.out_func, bus.out_fmt, bus.out_cause}),
          64'({8'h01, 8'h08, 3'd0}));

    // Legality causes
    tier = 8'd0;
    send(32'h8000_0820, 32'h0, 2'd0, 8'h01);
    check("t2_tier_low", 64'({bus.out_illegal, bus.out_cause}), 64'({1'b1, 3'd3}));
    send(32'h0000_0801, 32'h0, 2'd0, 8'h02);
    check("t2_no_vendor", 64'(bus.out_cause), 64'd1);
    send(32'h8000_080F, 32'h0, 2'd0, 8'h03);
    check("t2_unknown", 64'(bus.out_cause), 64'd2);
    tier = 8'd2;
    send(32'h8000_0801, 32'h0000_000F, 2'd0, 8'h04);
    check("t3_bad_mode", 64'(bus.out_cause), 64'd4);
    send(32'h8000_0810, 32'h0000_0003, 2'd3, 8'h05);
    check("t3_src_fmt", 64'({bus.out_src_fmt, bus.out_cause}), 64'({8'h03, 3'd0}));

    // Flags: accumulate, pre-update read, same-cycle clear+set
    flag_set_v = 1'b1; flag_set_ctx = 2'd2; flag_set = 5'b10001; flag_rd_ctx = 2'd2;
    #1;
    check("flag_pre_update", 64'(flag_rd_data), 64'd0);
    @(posedge clk); #1;
    flag_set = 5'b00100;
    @(posedge clk); #1;
    flag_set_v = 1'b0;
    #1;
    check("flag_accum", 64'(flag_rd_data), 64'(5'b10101));
    flag_set_v = 1'b1; flag_set = 5'b01000; flag_clr_v = 1'b1; flag_clr_ctx = 2'd2;
    @(posedge clk); #1;
    flag_set_v = 1'b0; flag_clr_v = 1'b0;
    #1;
    check("flag_clr_set", 64'(flag_rd_data), 64'(5'b01000));
    flag_rd_ctx = 2'd0;
    #1;
    check("flag_ctx0", 64'(flag_rd_data), 64'd0);
    mflags[2] = 5'b01000;
    @(posedge clk); #1;

    // Stream of 8 with a 3-cycle output stall
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'h8000_0201 + 32'(i), 32'h0, 2'(i), 8'h40 + 8'(i));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        rdy_fixed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_tag0", 64'({bus.out_valid, bus.out_tag}), 64'({1'b1, 8'h42}));
        @(posedge clk);
        @(negedge clk);
        check("stall_hold", 64'({bus.out_valid, bus.in_ready, bus.out_tag}),
              64'({1'b1, 1'b0, 8'h42}));
        rdy_fixed = 1'b1;
      end
    join
    drain_and_check();

    // Random ops under random back-pressure
    rdy_rand = 1'b1;
    repeat (150) rand_send();
    drain_and_check();

    // Random flag traffic against a per-context model
    for (int c = 0; c < NUM_CTX; c++) pend[c] = mflags[c];
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      for (int c = 0; c < NUM_CTX; c++) mflags[c] = pend[c];
      flag_set_v   = ($urandom_range(0, 1) == 1);
      flag_set_ctx = CTX_W'($urandom);
      flag_set     = 5'($urandom);
      flag_clr_v   = ($urandom_range(0, 3) == 0);
      flag_clr_ctx = CTX_W'($urandom);
      flag_rd_ctx  = CTX_W'($urandom);
      for (int c = 0; c < NUM_CTX; c++) begin
        pend[c] = ((flag_clr_v && (c == int'(flag_clr_ctx))) ? 5'h0 : mflags[c]) |
                  ((flag_set_v && (c == int'(flag_set_ctx))) ? flag_set : 5'h0);
      end
      #1;
      check("flag_rand", 64'(flag_rd_data), 64'(mflags[flag_rd_ctx]));
    end
    @(posedge clk); #1;
    flag_set_v = 1'b0; flag_clr_v = 1'b0;

    // Reset with output register and skid both holding ops
    flag_set_v = 1'b1; flag_set_ctx = 2'd1; flag_set = 5'h1F;
    @(posedge clk); #1;
    flag_set_v = 1'b0;
    rdy_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tier = 8'd0;
    send(32'h8000_0820, 32'h0, 2'd1, 8'hA0);
    send(32'h8000_0801, 32'h0, 2'd2, 8'hA1);
    check("pre_rst_full", 64'({bus.out_valid, bus.in_ready}), 64'({1'b1, 1'b0}));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'({bus.out_valid, bus.in_ready}), 64'd0);
    check("async_rst_cnt", 64'(illegal_cnt), 64'd0);
    flag_rd_ctx = 2'd1;
    #1;
    check("async_rst_flags", 64'(flag_rd_data), 64'd0);
    sb.delete();
    model_ill_cnt = 0;
    for (int c = 0; c < NUM_CTX; c++) mflags[c] = 5'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_fixed = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Recovery after reset
    rdy_rand = 1'b1;
    repeat (30) rand_send();
    drain_and_check();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
